// File: rtl/hazard_ctrl.sv
// hazard_ctrl: pipeline hazard and data-memory wait controller for the
// five-stage RV32I core.
//
// Ports:
//   clk_i, rst_ni              clock, asynchronous active-low reset
//   Rs1D_i, Rs2D_i             source registers in Decode
//   Rs1E_i, Rs2E_i             source registers in Execute
//   RdE_i, RdM_i, RdW_i        destination registers in Execute/Memory/Writeback
//   ResultSrcE_i               Execute result select (2'b01 = load)
//   RegWriteM_i, RegWriteW_i   register write enables in Memory/Writeback
//   PCSrcE_i                   taken branch/jump resolved in Execute
//   MemAccessM_i               Memory-stage instruction is a load or store
//   DMemReady_i                data memory completes the access this cycle
//   DMemReq_o                  data memory request strobe
//   StallF_o..StallM_o         hold the fetch/decode/execute/memory registers
//   FlushD_o, FlushE_o,
//   FlushW_o                   clear decode/execute/writeback registers
//   ForwardAE_o, ForwardBE_o   operand select: 00 regfile, 01 W, 10 M ALU
//   MemTimeout_o               sticky memory timeout flag (registered)
module hazard_ctrl #(
  parameter int unsigned REGISTER_ADDRESS_WIDTH = 5,
  parameter int unsigned TIMEOUT_CYCLES         = 255,
  parameter int unsigned CNT_WIDTH              = 8
) (
  input  logic                              clk_i,
  input  logic                              rst_ni,
  input  logic [REGISTER_ADDRESS_WIDTH-1:0] Rs1D_i,
  input  logic [REGISTER_ADDRESS_WIDTH-1:0] Rs2D_i,
  input  logic [REGISTER_ADDRESS_WIDTH-1:0] Rs1E_i,
  input  logic [REGISTER_ADDRESS_WIDTH-1:0] Rs2E_i,
  input  logic [REGISTER_ADDRESS_WIDTH-1:0] RdE_i,
  input  logic [REGISTER_ADDRESS_WIDTH-1:0] RdM_i,
  input  logic [REGISTER_ADDRESS_WIDTH-1:0] RdW_i,
  input  logic [1:0]                        ResultSrcE_i,
  input  logic                              RegWriteM_i,
  input  logic                              RegWriteW_i,
  input  logic                              PCSrcE_i,
  input  logic                              MemAccessM_i,
  input  logic                              DMemReady_i,
  output logic                              DMemReq_o,
  output logic                              StallF_o,
  output logic                              StallD_o,
  output logic                              StallE_o,
  output logic                              StallM_o,
  output logic                              FlushD_o,
  output logic                              FlushE_o,
  output logic                              FlushW_o,
  output logic [1:0]                        ForwardAE_o,
  output logic [1:0]                        ForwardBE_o,
  output logic                              MemTimeout_o
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_WAIT = 2'b01,
    ST_ERR  = 2'b10
  } mem_state_t;

  localparam logic [CNT_WIDTH-1:0] CNT_LIMIT = CNT_WIDTH'(TIMEOUT_CYCLES);
  localparam logic [CNT_WIDTH-1:0] CNT_ONE   = CNT_WIDTH'(1);

  mem_state_t           state_q, state_d;
  logic [CNT_WIDTH-1:0] cnt_q, cnt_d;
  logic                 mem_timeout_q;
  logic                 mem_stall;
  logic                 lw_stall;

  // Memory wait FSM: counts stalled WAIT cycles and parks in ERR on timeout.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    mem_stall = 1'b0;
    DMemReq_o = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        DMemReq_o = MemAccessM_i;
        if (MemAccessM_i && !DMemReady_i) begin
          mem_stall = 1'b1;
          state_d   = ST_WAIT;
          cnt_d     = CNT_ONE;
        end
      end
      ST_WAIT: begin
        DMemReq_o = 1'b1;
        // A ready seen on the limit cycle still counts as completion.
        if (DMemReady_i) begin
          state_d = ST_IDLE;
          cnt_d   = '0;
        end else begin
          mem_stall = 1'b1;
          if (cnt_q == CNT_LIMIT) begin
            state_d = ST_ERR;
          end else begin
            cnt_d = cnt_q + CNT_ONE;
          end
        end
      end
      ST_ERR: begin
        mem_stall = 1'b1;
      end
      default: begin
        state_d = ST_IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q       <= ST_IDLE;
      cnt_q         <= '0;
      mem_timeout_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      mem_timeout_q <= (state_d == ST_ERR);
    end
  end

  assign MemTimeout_o = mem_timeout_q;

  // Load-use hazard: the load in Execute writes a register Decode reads.
  assign lw_stall = (ResultSrcE_i == 2'b01) && (RdE_i != '0) &&
                    ((RdE_i == Rs1D_i) || (RdE_i == Rs2D_i));

  // While frozen on memory, flushes are held off so a pending branch in
  // Execute takes effect on the release cycle instead of being lost.
  always_comb begin
    StallF_o = 1'b0;
    StallD_o = 1'b0;
    StallE_o = 1'b0;
    StallM_o = 1'b0;
    FlushD_o = 1'b0;
    FlushE_o = 1'b0;
    FlushW_o = 1'b0;
    if (mem_stall) begin
      StallF_o = 1'b1;
      StallD_o = 1'b1;
      StallE_o = 1'b1;
      StallM_o = 1'b1;
      FlushW_o = 1'b1;
    end else if (PCSrcE_i) begin
      FlushD_o = 1'b1;
      FlushE_o = 1'b1;
    end else if (lw_stall) begin
      StallF_o = 1'b1;
      StallD_o = 1'b1;
      FlushE_o = 1'b1;
    end
  end

  function automatic logic [1:0] fwd_sel(
    input logic [REGISTER_ADDRESS_WIDTH-1:0] rs,
    input logic [REGISTER_ADDRESS_WIDTH-1:0] rd_m,
    input logic [REGISTER_ADDRESS_WIDTH-1:0] rd_w,
    input logic                              we_m,
    input logic                              we_w
  );
    logic [1:0] sel;
    sel = 2'b00;
    if (we_m && (rd_m != '0) && (rd_m == rs)) begin
      sel = 2'b10;
    end else if (we_w && (rd_w != '0) && (rd_w == rs)) begin
      sel = 2'b01;
    end
    return sel;
  endfunction

  assign ForwardAE_o = fwd_sel(Rs1E_i, RdM_i, RdW_i, RegWriteM_i, RegWriteW_i);
  assign ForwardBE_o = fwd_sel(Rs2E_i, RdM_i, RdW_i, RegWriteM_i, RegWriteW_i);

endmodule
